// File: rtl/hub75_rx.sv
// HUB75 receiver: synchronises the panel bus and turns each shifted line into {row,col} RAM writes.
// Optional glitch filter on CLK/LAT edges: define HUB75_RX_DEGLITCH_EN.
`timescale 1ns/1ps

module hub75_rx #(
    parameter int COL_BITS    = 8,
    parameter int ROW_BITS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         pin_clk,
    input  logic                         rst,
    input  logic                         hub_clk_in,
    input  logic                         hub_lat_in,
    input  logic                         hub_oe_in,
    input  logic [ROW_BITS-1:0]          hub_row_in,
    input  logic [5:0]                   hub_rgb_in,
    output logic [ROW_BITS+COL_BITS-1:0] ram_addr,
    output logic [5:0]                   ram_data,
    output logic                         ram_we,
    output logic                         line_done,
    output logic                         frame_start,
    output logic                         oe_active,
    output logic                         err_overflow,
    output logic                         err_short,
    input  logic                         clr_err
);

    localparam int IW = 3 + ROW_BITS + 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic [IW-1:0]       r_sync [SYNC_STAGES];
    logic [IW-1:0]       w_s;
    logic                w_s_clk;
    logic                w_s_lat;
    logic                w_s_oe;
    logic [ROW_BITS-1:0] w_s_row;
    logic [5:0]          w_s_rgb;

    logic                r_clk_d;
    logic                r_lat_d;
    logic                w_clk_rise;
    logic                w_lat_rise;

    logic                r_clk_edge;
    logic                r_lat_edge;
    logic [ROW_BITS-1:0] r_row_e;
    logic [5:0]          r_rgb_e;

    state_t              r_state;
    logic [COL_BITS-1:0] r_col;
    logic [ROW_BITS-1:0] r_prev_row;
    logic                w_col_last;
    logic                w_short;

    // All HUB75 inputs travel through one shared chain so they stay cycle-aligned.
    always_ff @(posedge pin_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= {hub_clk_in, hub_lat_in, hub_oe_in, hub_row_in, hub_rgb_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_s     = r_sync[SYNC_STAGES-1];
    assign w_s_clk = w_s[IW-1];
    assign w_s_lat = w_s[IW-2];
    assign w_s_oe  = w_s[IW-3];
    assign w_s_row = w_s[6 +: ROW_BITS];
    assign w_s_rgb = w_s[5:0];

    always_ff @(posedge pin_clk) begin
        if (rst) begin
            r_clk_d <= 1'b0;
            r_lat_d <= 1'b0;
        end else begin
            r_clk_d <= w_s_clk;
            r_lat_d <= w_s_lat;
        end
    end

`ifdef HUB75_RX_DEGLITCH_EN
    logic r_clk_d2;
    logic r_lat_d2;

    always_ff @(posedge pin_clk) begin
        if (rst) begin
            r_clk_d2 <= 1'b0;
            r_lat_d2 <= 1'b0;
        end else begin
            r_clk_d2 <= r_clk_d;
            r_lat_d2 <= r_lat_d;
        end
    end

    // A rise counts once the new level has been seen on two consecutive cycles.
    assign w_clk_rise = w_s_clk & r_clk_d & ~r_clk_d2;
    assign w_lat_rise = w_s_lat & r_lat_d & ~r_lat_d2;
`else
    assign w_clk_rise = w_s_clk & ~r_clk_d;
    assign w_lat_rise = w_s_lat & ~r_lat_d;
`endif

    // Edge stage: capture the pixel and row alongside the edge that qualifies them.
    always_ff @(posedge pin_clk) begin
        if (rst) begin
            r_clk_edge <= 1'b0;
            r_lat_edge <= 1'b0;
            r_row_e    <= '0;
            r_rgb_e    <= '0;
            oe_active  <= 1'b0;
        end else begin
            r_clk_edge <= w_clk_rise;
            r_lat_edge <= w_lat_rise;
            r_row_e    <= w_s_row;
            r_rgb_e    <= w_s_rgb;
            oe_active  <= ~w_s_oe;
        end
    end

    assign w_col_last = (r_col == {COL_BITS{1'b1}});
    // Judged after any same-cycle CLK write: a line completed by that write is not short.
    assign w_short = (r_state == ST_IDLE) ||
                     ((r_state == ST_SHIFT) && !(r_clk_edge && w_col_last));

    always_ff @(posedge pin_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_prev_row   <= {ROW_BITS{1'b1}};
            ram_addr     <= '0;
            ram_data     <= '0;
            ram_we       <= 1'b0;
            line_done    <= 1'b0;
            frame_start  <= 1'b0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
        end else begin
            ram_we      <= 1'b0;
            line_done   <= 1'b0;
            frame_start <= 1'b0;

            if (clr_err) begin
                err_overflow <= 1'b0;
                err_short    <= 1'b0;
            end

            if (r_clk_edge) begin
                case (r_state)
                    ST_IDLE, ST_SHIFT: begin
                        ram_we   <= 1'b1;
                        ram_addr <= {r_row_e, r_col};
                        ram_data <= r_rgb_e;
                        r_col    <= r_col + 1'b1;
                        r_state  <= w_col_last ? ST_FULL : ST_SHIFT;
                    end
                    default: begin
                        err_overflow <= 1'b1;
                    end
                endcase
            end

            // Latch handling comes last so its col/state updates override the CLK path.
            if (r_lat_edge) begin
                line_done   <= 1'b1;
                if (w_short) begin
                    err_short <= 1'b1;
                end
                r_col       <= '0;
                r_state     <= ST_IDLE;
                frame_start <= (r_row_e == '0) && (r_prev_row == {ROW_BITS{1'b1}});
                r_prev_row  <= r_row_e;
            end
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: expected RAM writes are queued as pixels are driven and popped by a write monitor.
`timescale 1ns/1ps

module tb_hub75_rx;

    localparam int SYNC = 2;
`ifdef HUB75_RX_DEGLITCH_EN
    localparam int LAT_EXP = SYNC + 3;
`else
    localparam int LAT_EXP = SYNC + 2;
`endif

    logic        pin_clk;
    logic        rst;
    logic        hub_clk_in;
    logic        hub_lat_in;
    logic        hub_oe_in;
    logic [3:0]  hub_row_in;
    logic [5:0]  hub_rgb_in;
    logic [11:0] ram_addr;
    logic [5:0]  ram_data;
    logic        ram_we;
    logic        line_done;
    logic        frame_start;
    logic        oe_active;
    logic        err_overflow;
    logic        err_short;
    logic        clr_err;

    hub75_rx #(.COL_BITS(8), .ROW_BITS(4), .SYNC_STAGES(SYNC)) dut (
        .pin_clk     (pin_clk),
        .rst         (rst),
        .hub_clk_in  (hub_clk_in),
        .hub_lat_in  (hub_lat_in),
        .hub_oe_in   (hub_oe_in),
        .hub_row_in  (hub_row_in),
        .hub_rgb_in  (hub_rgb_in),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .line_done   (line_done),
        .frame_start (frame_start),
        .oe_active   (oe_active),
        .err_overflow(err_overflow),
        .err_short   (err_short),
        .clr_err     (clr_err)
    );

    initial pin_clk = 1'b0;
    always #5 pin_clk = ~pin_clk;

    logic [17:0] q[$];
    int checks = 0;
    int errors = 0;
    int ld_cnt = 0;
    int fs_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge pin_clk) begin
        if (!rst) begin
            if (line_done)   ld_cnt++;
            if (frame_start) fs_cnt++;
            if (ram_we) begin
                logic [17:0] e;
                wr_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_write", {20'd0, ram_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("wr_addr", {20'd0, ram_addr}, {20'd0, e[17:6]});
                    chk("wr_data", {26'd0, ram_data}, {26'd0, e[5:0]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed no finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge pin_clk);
    endtask

    task automatic pixel(input logic [3:0] row, input logic [5:0] rgb);
        hub_row_in = row;
        hub_rgb_in = rgb;
        hub_clk_in = 1'b0;
        cyc(2);
        hub_clk_in = 1'b1;
        cyc(2);
        hub_clk_in = 1'b0;
    endtask

    task automatic line(input logic [3:0] row, input int c0, input int n, input logic [5:0] seed);
        logic [7:0] col8;
        logic [5:0] d;
        for (int c = c0; c < c0 + n; c++) begin
            col8 = c[7:0];
            d    = col8[5:0] ^ seed;
            q.push_back({row, col8, d});
            pixel(row, d);
        end
    endtask

    task automatic latch();
        hub_clk_in = 1'b0;
        hub_lat_in = 1'b0;
        cyc(2);
        hub_lat_in = 1'b1;
        cyc(2);
        hub_lat_in = 1'b0;
        cyc(2);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && q.size() != 0; i++) cyc(1);
        cyc(6);
        chk(tag, q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        cyc(1);
        clr_err = 1'b0;
        cyc(1);
    endtask

    int ld0, fs0, wr0, lat_cnt;

    initial begin
        rst = 1'b1; hub_clk_in = 1'b0; hub_lat_in = 1'b0; hub_oe_in = 1'b1;
        hub_row_in = '0; hub_rgb_in = '0; clr_err = 1'b0;
        cyc(4);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_strobes", {line_done, frame_start}, 0);
        chk("rst_errs", {err_overflow, err_short}, 0);
        chk("rst_oe_active", oe_active, 0);
        rst = 1'b0;
        cyc(6);
        chk("oe_idle", oe_active, 0);
        hub_oe_in = 1'b0;
        cyc(6);
        chk("oe_on", oe_active, 1);
        hub_oe_in = 1'b1;

        // Full line on row 5, RGB = col[5:0]; first pixel also measures edge-to-write latency.
        ld0 = ld_cnt;
        hub_row_in = 4'd5;
        hub_rgb_in = 6'd0;
        q.push_back({4'd5, 8'd0, 6'd0});
        cyc(2);
        hub_clk_in = 1'b1;
        lat_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (k == 2) hub_clk_in = 1'b0;
            if (ram_we && lat_cnt == 0) lat_cnt = k;
        end
        chk("latency", lat_cnt, LAT_EXP);
        line(4'd5, 1, 255, 6'd0);
        latch();
        drain("line5_drain");
        chk("line5_line_done", ld_cnt - ld0, 1);
        chk("line5_errs", {err_overflow, err_short}, 0);

        // Loopback-style frame of 16 rows, pixsyn address order.
        do_reset();
        fs0 = fs_cnt; wr0 = wr_cnt; ld0 = ld_cnt;
        for (int r = 0; r < 16; r++) begin
            line(r[3:0], 0, 256, 6'(r * 5 + 3));
            latch();
            if (r == 0) begin
                cyc(2);
                chk("frame_start_row0", fs_cnt - fs0, 1);
            end
        end
        drain("frame_drain");
        chk("frame_writes", wr_cnt - wr0, 4096);
        chk("frame_start_once", fs_cnt - fs0, 1);
        chk("frame_line_done", ld_cnt - ld0, 16);
        chk("frame_errs", {err_overflow, err_short}, 0);

        // 257 pulses: last one is dropped and flags overflow.
        ld0 = ld_cnt; wr0 = wr_cnt;
        line(4'd2, 0, 256, 6'h15);
        pixel(4'd2, 6'h3F);
        latch();
        drain("ovf_drain");
        chk("ovf_writes", wr_cnt - wr0, 256);
        chk("ovf_err_overflow", err_overflow, 1);
        chk("ovf_err_short", err_short, 0);
        chk("ovf_line_done", ld_cnt - ld0, 1);
        clear_errors();
        chk("ovf_cleared", err_overflow, 0);

        // Short line, then the next line restarts at col 0.
        ld0 = ld_cnt;
        line(4'd3, 0, 100, 6'h2A);
        latch();
        drain("short_drain");
        chk("short_err_short", err_short, 1);
        chk("short_err_overflow", err_overflow, 0);
        chk("short_line_done", ld_cnt - ld0, 1);
        line(4'd3, 0, 3, 6'h01);
        latch();
        drain("short_next_drain");
        clear_errors();
        chk("short_cleared", {err_overflow, err_short}, 0);

        // CLK and LAT rising together on col 255.
        ld0 = ld_cnt;
        line(4'd4, 0, 255, 6'h0C);
        q.push_back({4'd4, 8'd255, 6'h33});
        hub_rgb_in = 6'h33;
        hub_clk_in = 1'b0;
        cyc(2);
        hub_clk_in = 1'b1;
        hub_lat_in = 1'b1;
        cyc(2);
        hub_clk_in = 1'b0;
        hub_lat_in = 1'b0;
        cyc(2);
        drain("simul_drain");
        chk("simul_line_done", ld_cnt - ld0, 1);
        chk("simul_errs", {err_overflow, err_short}, 0);
        line(4'd4, 0, 1, 6'h00);
        latch();
        drain("simul_idle_drain");
        clear_errors();

        // Reset mid-line, then a fresh row-0 line.
        line(4'd0, 0, 40, 6'h11);
        drain("abort_drain");
        ld0 = ld_cnt;
        do_reset();
        cyc(4);
        chk("abort_no_line_done", ld_cnt - ld0, 0);
        fs0 = fs_cnt;
        line(4'd0, 0, 256, 6'h22);
        latch();
        drain("fresh_drain");
        chk("fresh_line_done", ld_cnt - ld0, 1);
        chk("fresh_frame_start", fs_cnt - fs0, 1);
        chk("fresh_errs", {err_overflow, err_short}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
